// File: rtl/fetch_pkg.sv
// Shared types and constants for the multicycle instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_fields_t;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [5:0]  OPC_RTYPE = 6'h00;
  localparam logic [5:0]  OPC_J     = 6'h02;
  localparam logic [5:0]  OPC_BEQ   = 6'h04;

endpackage

// File: rtl/ir_field_split.sv
// Combinational slicer of the instruction register into MIPS fields.
module ir_field_split
  import fetch_pkg::*;
(
  input  logic [31:0]   ir,
  output instr_fields_t fields,
  output logic [15:0]   imm16
);

  // The struct layout mirrors the R-type encoding, so a straight cast suffices.
  assign fields = instr_fields_t'(ir);
  assign imm16  = ir[15:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle MIPS fetch: PC + IR registers, ISSUE/WAIT/CAPTURE sequencing of
// instruction memory; fetch_done MEM_LATENCY+1 cycles after fetch_req is sampled;
// requests arriving while busy are dropped. FETCH_ALIGN_CHECK_EN rejects misaligned pc_load.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          MEM_LATENCY = 2,
  parameter logic [31:0] PC_RESET    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        busy,
  output logic        fetch_done,
  output logic        addr_err,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  fetch_state_t  state, state_nx;
  logic [3:0]    wait_cnt;
  logic [31:0]   pc_q;
  logic [31:0]   ir_q;
  logic          load_ok;
  instr_fields_t fields;

`ifdef FETCH_ALIGN_CHECK_EN
  logic addr_err_q;

  assign load_ok = (pc_next[1:0] == 2'b00);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= (state == IDLE) && pc_load && !load_ok;
    end
  end

  assign addr_err = addr_err_q;
`else
  logic unused_pc_lsb;

  assign load_ok       = 1'b1;
  assign unused_pc_lsb = ^pc_next[1:0];
  assign addr_err      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      pc_q     <= PC_RESET;
      ir_q     <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE:    if (pc_load && load_ok) pc_q <= {pc_next[31:2], 2'b00};
        ISSUE:   wait_cnt <= LAT_M1;
        WAIT:    wait_cnt <= wait_cnt - 4'd1;
        CAPTURE: begin
          ir_q <= mem_rdata;
          pc_q <= pc_q + PC_STEP;
        end
        default: ;
      endcase
    end
  end

  // pc_load takes priority so a following fetch uses the freshly loaded PC.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!pc_load && fetch_req) state_nx = ISSUE;
      ISSUE:   state_nx = (MEM_LATENCY > 1) ? WAIT : CAPTURE;
      WAIT:    if (wait_cnt == 4'd1) state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign mem_rd     = (state != IDLE);
  assign fetch_done = (state == CAPTURE);
  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign instr      = ir_q;

  ir_field_split u_split (
    .ir     (ir_q),
    .fields (fields),
    .imm16  (imm16)
  );

  assign opcode = fields.opcode;
  assign rs     = fields.rs;
  assign rt     = fields.rt;
  assign rd     = fields.rd;
  assign shamt  = fields.shamt;
  assign funct  = fields.funct;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one DUT at MEM_LATENCY=2, one at MEM_LATENCY=1.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  // Instruction memory contents (hand-encoded).
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: imem = 32'h8C22_0004; // lw $2,4($1)
      32'h0000_0004: imem = 32'h0043_2020; // add $4,$2,$3
      32'h0000_0008: imem = 32'h0800_0010; // j 0x40
      32'hFFFF_FFFC: imem = 32'h1000_FFFF; // beq $0,$0,-1
      default:       imem = 32'hDEAD_BEEF;
    endcase
  endfunction

  // DUT 0: MEM_LATENCY = 2
  logic        fetch_req = 0, pc_load = 0;
  logic [31:0] pc_next = 0, mem_rdata, mem_addr, pc, instr;
  logic        mem_rd, busy, fetch_done, addr_err;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  assign mem_rdata = imem(mem_addr);

  instr_fetch_unit #(.MEM_LATENCY(2), .PC_RESET(32'h0)) dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_next(pc_next), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .busy(busy), .fetch_done(fetch_done), .addr_err(addr_err), .pc(pc),
    .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16)
  );

  // DUT 1: MEM_LATENCY = 1
  logic        fetch_req1 = 0, pc_load1 = 0;
  logic [31:0] pc_next1 = 0, mem_rdata1, mem_addr1, pc1, instr1;
  logic        mem_rd1, busy1, fetch_done1, addr_err1;
  logic [5:0]  opcode1, funct1;
  logic [4:0]  rs1, rt1, rd1, shamt1;
  logic [15:0] imm16_1;

  assign mem_rdata1 = imem(mem_addr1);

  instr_fetch_unit #(.MEM_LATENCY(1), .PC_RESET(32'h0)) dut1 (
    .clock(clock), .reset(reset), .fetch_req(fetch_req1), .pc_load(pc_load1),
    .pc_next(pc_next1), .mem_rdata(mem_rdata1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .busy(busy1), .fetch_done(fetch_done1), .addr_err(addr_err1), .pc(pc1),
    .instr(instr1), .opcode(opcode1), .rs(rs1), .rt(rt1), .rd(rd1), .shamt(shamt1),
    .funct(funct1), .imm16(imm16_1)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, 32'h0); end
    checks++; if ({mem_rd, busy, fetch_done, addr_err} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_rd, busy, fetch_done, addr_err}); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h0); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_first_fetch();
    fetch_req = 1'b1;
    tick(); // ISSUE
    fetch_req = 1'b0;
    checks++; if ({mem_rd, fetch_done} !== 2'b10) begin errors++; $display("FAIL ff_issue: got %b expected 10", {mem_rd, fetch_done}); end
    tick(); // WAIT
    checks++; if ({mem_rd, fetch_done} !== 2'b10) begin errors++; $display("FAIL ff_wait: got %b expected 10", {mem_rd, fetch_done}); end
    tick(); // CAPTURE
    checks++; if ({mem_rd, fetch_done} !== 2'b11) begin errors++; $display("FAIL ff_capture: got %b expected 11", {mem_rd, fetch_done}); end
    tick(); // IDLE
    checks++; if ({mem_rd, fetch_done, busy} !== 3'b000) begin errors++; $display("FAIL ff_idle: got %b expected 000", {mem_rd, fetch_done, busy}); end
    checks++; if (instr !== 32'h8C22_0004) begin errors++; $display("FAIL ff_instr: got %h expected %h", instr, 32'h8C22_0004); end
    checks++; if ({opcode, rs, rt, imm16} !== {6'h23, 5'd1, 5'd2, 16'd4}) begin errors++; $display("FAIL ff_fields: got %h/%0d/%0d/%h expected 23/1/2/0004", opcode, rs, rt, imm16); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL ff_pc: got %h expected %h", pc, 32'h4); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    exp_pc = 32'h4;
    fetch_req = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++; if (mem_addr !== exp_pc) begin errors++; $display("FAIL b2b_addr: fetch %0d cycle %0d got %h expected %h", f, c, mem_addr, exp_pc); end
        checks++; if (fetch_done !== (c == 2)) begin errors++; $display("FAIL b2b_done: fetch %0d cycle %0d got %b expected %b", f, c, fetch_done, (c == 2)); end
      end
      tick();
      if (f == 1) fetch_req = 1'b0;
      checks++; if (pc !== exp_pc + 32'd4) begin errors++; $display("FAIL b2b_pc: got %h expected %h", pc, exp_pc + 32'd4); end
      checks++; if (instr !== imem(exp_pc)) begin errors++; $display("FAIL b2b_instr: got %h expected %h", instr, imem(exp_pc)); end
      exp_pc = exp_pc + 32'd4;
    end
    // last captured word was the jump at 0x8; previous was the add at 0x4
    checks++; if (opcode !== OPC_J) begin errors++; $display("FAIL b2b_opcode: got %h expected %h", opcode, OPC_J); end
  endtask

  task automatic test_pc_load();
    pc_load = 1'b1; pc_next = 32'h0000_0040; fetch_req = 1'b1;
    tick();
    pc_load = 1'b0;
    checks++; if ({pc, busy} !== {32'h40, 1'b0}) begin errors++; $display("FAIL load_pc: got %h busy %b expected 40 busy 0", pc, busy); end
    tick(); // ISSUE from new PC
    fetch_req = 1'b0;
    checks++; if ({mem_addr, busy} !== {32'h40, 1'b1}) begin errors++; $display("FAIL load_issue: got %h busy %b expected 40 busy 1", mem_addr, busy); end
    tick(); // WAIT: load while busy must be ignored
    pc_load = 1'b1; pc_next = 32'h0000_0100; fetch_req = 1'b1;
    tick(); // CAPTURE
    pc_load = 1'b0; fetch_req = 1'b0;
    checks++; if ({fetch_done, mem_addr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL load_capture: got %b/%h expected 1/00000040", fetch_done, mem_addr); end
    tick();
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL load_done_pc: got %h expected %h", pc, 32'h44); end
    checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_instr: got %h expected %h", instr, 32'hDEAD_BEEF); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore: busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_fetch();
    int done_seen;
    done_seen = 0;
    fetch_req = 1'b1;
    tick(); // ISSUE
    fetch_req = 1'b0;
    tick(); // WAIT
    reset = 1'b0;
    #1;
    checks++; if ({mem_rd, busy} !== 2'b00) begin errors++; $display("FAIL rst_mid_ctrl: got %b expected 00", {mem_rd, busy}); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_mid_pc: got %h expected %h", pc, 32'h0); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fetch_done) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_mid_done: got %0d pulses expected 0", done_seen); end
    checks++; if ({instr, pc} !== 64'h0) begin errors++; $display("FAIL rst_mid_state: instr %h pc %h expected 0/0", instr, pc); end
  endtask

  task automatic test_latency1_wrap();
    pc_load1 = 1'b1; pc_next1 = 32'hFFFF_FFFC;
    tick();
    pc_load1 = 1'b0;
    checks++; if (pc1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL l1_load: got %h expected %h", pc1, 32'hFFFF_FFFC); end
    fetch_req1 = 1'b1;
    tick(); // ISSUE
    fetch_req1 = 1'b0;
    checks++; if ({mem_rd1, fetch_done1} !== 2'b10) begin errors++; $display("FAIL l1_issue: got %b expected 10", {mem_rd1, fetch_done1}); end
    tick(); // CAPTURE directly
    checks++; if ({mem_rd1, fetch_done1} !== 2'b11) begin errors++; $display("FAIL l1_capture: got %b expected 11", {mem_rd1, fetch_done1}); end
    tick();
    checks++; if ({busy1, pc1} !== {1'b0, 32'h0}) begin errors++; $display("FAIL l1_wrap: busy %b pc %h expected 0/00000000", busy1, pc1); end
    checks++; if ({opcode1, imm16_1} !== {OPC_BEQ, 16'hFFFF}) begin errors++; $display("FAIL l1_fields: got %h/%h expected 04/ffff", opcode1, imm16_1); end
  endtask

  task automatic test_align();
    pc_load = 1'b1; pc_next = 32'h0000_0042;
    tick();
    pc_load = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if ({pc, addr_err} !== {32'h0, 1'b1}) begin errors++; $display("FAIL align_reject: pc %h err %b expected 0/1", pc, addr_err); end
`else
    checks++; if ({pc, addr_err} !== {32'h40, 1'b0}) begin errors++; $display("FAIL align_force: pc %h err %b expected 40/0", pc, addr_err); end
`endif
    tick();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL align_pulse: err got %b expected 0", addr_err); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_pc_load();
    test_reset_mid_fetch();
    test_latency1_wrap();
    test_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multicycle fetch stage for the MIPS CPU.
- Holds the PC and sequences instruction-memory reads, including wait states.
- Captures the fetched word into the instruction register (IR) and exposes decoded fields to the control unit.
- Control unit requests a fetch; this block reports completion and performs PC+4. Branch and jump targets are loaded through a separate load port.

Parameters:
- MEM_LATENCY, 2: cycles from address presented to mem_rdata valid; legal range 1..15.
- PC_RESET, 32'h0000_0000: PC value after reset.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  request an instruction fetch; sampled only in IDLE.
- pc_load  in  1  load pc_next into PC; honoured only in IDLE.
- pc_next  in  32  branch/jump/ALU target.
- mem_rdata  in  32  instruction memory read data.
- mem_addr  out  32  instruction memory address.
- mem_rd  out  1  memory read strobe.
- busy  out  1  high in any state other than IDLE.
- fetch_done  out  1  one-cycle pulse in CAPTURE.
- addr_err  out  1  misaligned-load pulse (optional feature); tied 0 when the feature is compiled out.
- pc  out  32  current PC.
- instr  out  32  IR contents.
- opcode  out  6  IR[31:26].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- shamt  out  5  IR[10:6].
- funct  out  6  IR[5:0].
- imm16  out  16  IR[15:0].

Behaviour:
- Reset (reset=0, asynchronous, also mid-fetch):
  - state=IDLE, pc=PC_RESET, IR=0, wait counter=0.
  - mem_rd=0, mem_addr=PC_RESET, fetch_done=0, busy=0, addr_err=0.
  - An aborted fetch does not update PC or IR.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - pc_load=1: PC <= {pc_next[31:2],2'b00}; state stays IDLE. Any fetch_req is ignored this cycle; if fetch_req is still high next cycle, the fetch starts from the new PC.
  - pc_load=0 and fetch_req=1: go to ISSUE.
- ISSUE (1 cycle):
  - mem_rd=1, mem_addr=pc.
  - Load wait counter with MEM_LATENCY-1.
  - Next state: WAIT if MEM_LATENCY>1, else CAPTURE.
- WAIT:
  - mem_rd=1, mem_addr=pc, counter decrements each cycle.
  - Go to CAPTURE when counter reaches 1 (WAIT lasts MEM_LATENCY-1 cycles).
- CAPTURE (1 cycle):
  - mem_rd=1, fetch_done=1.
  - At the closing edge: IR <= mem_rdata, PC <= PC+4 (wraps modulo 2^32), state <= IDLE.
- Latency:
  - fetch_req sampled at edge E → fetch_done high during cycle E+MEM_LATENCY+1.
  - New instr and PC are visible from cycle E+MEM_LATENCY+2.
  - MEM_LATENCY=2: ISSUE, WAIT, CAPTURE, then IDLE.
- pc_load or fetch_req while busy: ignored, no side effect.
- mem_addr always equals pc, so it is stable for the whole fetch.
- IR and decoded fields:
  - IR holds its value between fetches.
  - Field outputs are combinational slices of IR.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - pc_load with pc_next[1:0]!=0 is rejected; PC is unchanged.
  - addr_err pulses high for exactly one cycle, the cycle after the load.
  - Aligned loads behave normally.
- Undefined:
  - pc_next[1:0] is silently forced to 00.
  - addr_err is constant 0.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, ISSUE, WAIT, CAPTURE}.
  - instr_fields_t packed struct (opcode, rs, rt, rd, shamt, funct).
  - Constants: PC_STEP=4, OPC_RTYPE=6'h00, OPC_J=6'h02, OPC_BEQ=6'h04.
- One natural sub-module: ir_field_split, a combinational slicer of IR into instr_fields_t plus imm16.
- FSM, counter, PC and IR registers stay in instr_fetch_unit.

Test Plan:
- Reset release, MEM_LATENCY=2, fetch_req=1 at edge 1, memory returns 32'h8C22_0004 at addr 0:
  - mem_rd high cycles 2-4, fetch_done high only in cycle 4.
  - instr=32'h8C22_0004, opcode=6'h23, rs=1, rt=2, imm16=4, pc=4 in cycle 5.
- Back-to-back fetches with fetch_req held high: PC sequence 0→4→8, fetch_done every 4 cycles, mem_addr steady within each fetch.
- In IDLE, pc_load=1, pc_next=32'h0000_0040 with fetch_req=1:
  - PC=0x40 next cycle; fetch starts one cycle later.
  - Completes with PC=0x44.
- Drop reset to 0 during WAIT:
  - Immediately mem_rd=0, busy=0, pc=PC_RESET.
  - IR keeps reset value 0 after reset release; no fetch_done.
- MEM_LATENCY=1: fetch_done in the second cycle after request, WAIT never entered. PC=32'hFFFF_FFFC fetch: PC wraps to 0.
- FETCH_ALIGN_CHECK_EN defined, pc_load with pc_next=32'h0000_0042: PC unchanged, addr_err high exactly one cycle. Without the macro: PC=0x40, addr_err=0.
